// File: rtl/fab_clk_enable_gen.sv
// fab_clk_enable_gen: NCH programmable clock-enable / divided-clock channels from FAB_CLK,
// with shadowed glitch-free ratio updates, per-channel bypass and a post-reset LOCK. Rev 1.0
`default_nettype none

module fab_clk_enable_gen #(
  parameter int NCH         = 3,
  parameter int DIV_W       = 16,
  parameter int DIV_RST     = 3,
  parameter int LOCK_CYCLES = 64
) (
  input  logic                 FAB_CLK,
  input  logic                 RESET,
  input  logic [NCH*DIV_W-1:0] DIV_CFG,
  input  logic [NCH-1:0]       CFG_LOAD,
  input  logic [NCH-1:0]       BYPASS,
  input  logic [NCH-1:0]       CH_EN,
  output logic [NCH-1:0]       CLK_EN,
  output logic [NCH-1:0]       CLK_DIV,
  output logic [NCH-1:0]       CFG_PEND,
  output logic                 LOCK
);

  localparam int LCW = $clog2(LOCK_CYCLES + 1);
  localparam logic [0:0] WAIT_LOCK = 1'b0;
  localparam logic [0:0] LOCKED    = 1'b1;
  localparam logic [DIV_W-1:0] RST_R = DIV_W'(DIV_RST);

  logic [0:0]     lock_state;
  logic [LCW-1:0] lock_cnt;

  // LOCK rises on the edge after LOCK_CYCLES edges have been counted.
  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      lock_state <= WAIT_LOCK;
      lock_cnt   <= '0;
    end else if (lock_state == WAIT_LOCK) begin
      if (lock_cnt == LCW'(LOCK_CYCLES)) begin
        lock_state <= LOCKED;
      end else begin
        lock_cnt <= lock_cnt + LCW'(1);
      end
    end
  end

  assign LOCK = (lock_state == LOCKED);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] active;
    logic [DIV_W-1:0] shadow;
    logic             pend;
    logic             en_q;
    logic             div_q;
    logic [DIV_W-1:0] cfg;
    logic             run;
    logic [DIV_W-1:0] reload;

    assign cfg    = DIV_CFG[i*DIV_W +: DIV_W];
    assign run    = CH_EN[i] & ~BYPASS[i] & LOCK;
    // A load landing on the reload cycle wins over the older shadow value.
    assign reload = CFG_LOAD[i] ? cfg : shadow;

    always_ff @(posedge FAB_CLK or posedge RESET) begin
      if (RESET) begin
        cnt    <= RST_R;
        active <= RST_R;
        shadow <= RST_R;
        pend   <= 1'b0;
        en_q   <= 1'b0;
        div_q  <= 1'b0;
      end else if (!run) begin
        cnt    <= reload;
        active <= reload;
        shadow <= reload;
        pend   <= 1'b0;
        en_q   <= CH_EN[i] & BYPASS[i] & LOCK;
        div_q  <= 1'b0;
      end else begin
        en_q  <= (cnt == '0);
        div_q <= (cnt > (active >> 1));
        if (cnt == '0) begin
          cnt    <= reload;
          active <= reload;
          shadow <= reload;
          pend   <= 1'b0;
        end else begin
          cnt <= cnt - DIV_W'(1);
          if (CFG_LOAD[i]) begin
            shadow <= cfg;
            pend   <= 1'b1;
          end
        end
      end
    end

    assign CLK_EN[i]   = en_q;
    assign CLK_DIV[i]  = div_q;
    assign CFG_PEND[i] = pend;
  end

endmodule

`default_nettype wire

// File: tb/tb_fab_clk_enable_gen.sv
// tb_fab_clk_enable_gen: directed, table-driven check of fab_clk_enable_gen. Rev 1.0
`default_nettype none

module tb_fab_clk_enable_gen;

  localparam int NCH   = 3;
  localparam int DIV_W = 16;

  logic                 clk;
  logic                 rst;
  logic [NCH*DIV_W-1:0] div_cfg;
  logic [NCH-1:0]       cfg_load;
  logic [NCH-1:0]       bypass;
  logic [NCH-1:0]       ch_en;
  logic [NCH-1:0]       clk_en;
  logic [NCH-1:0]       clk_div;
  logic [NCH-1:0]       cfg_pend;
  logic                 lock;

  int total = 0;
  int bad   = 0;

  fab_clk_enable_gen #(
    .NCH(NCH), .DIV_W(DIV_W), .DIV_RST(3), .LOCK_CYCLES(64)
  ) dut (
    .FAB_CLK(clk), .RESET(rst), .DIV_CFG(div_cfg), .CFG_LOAD(cfg_load),
    .BYPASS(bypass), .CH_EN(ch_en), .CLK_EN(clk_en), .CLK_DIV(clk_div),
    .CFG_PEND(cfg_pend), .LOCK(lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int r;
    int period;
    int high;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int c, input int r);
    logic [DIV_W-1:0] v;
    v = r[DIV_W-1:0];
    div_cfg[c*DIV_W +: DIV_W] = v;
  endtask

  // Ticks until clk_en[c] is seen; n = ticks taken, hi = clk_div[c] highs seen.
  task automatic wait_en(input int c, output int n, output int hi);
    n  = 0;
    hi = 0;
    do begin
      tick();
      n++;
      if (clk_div[c]) hi++;
    end while (!clk_en[c] && n < 300);
  endtask

  task automatic load_idle(input int c, input int r);
    ch_en[c] = 1'b0;
    tick();
    set_cfg(c, r);
    cfg_load[c] = 1'b1;
    tick();
    cfg_load[c] = 1'b0;
    ch_en[c] = 1'b1;
  endtask

  task automatic lock_seq(input string tag);
    int early;
    int n;
    int hi;
    early = 0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (lock || clk_en != '0 || clk_div != '0) early++;
    end
    check({tag, "_quiet_before_lock"}, early, 0);
    tick();
    check({tag, "_lock_at_65"}, int'(lock), 1);
    check({tag, "_no_en_at_lock"}, int'(clk_en[0]), 0);
    wait_en(0, n, hi);
    check({tag, "_first_en_after_lock"}, n, 4);
    wait_en(0, n, hi);
    check({tag, "_reset_ratio_period"}, n, 4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int hi;
    int cnt_bad;

    tbl[0] = '{ch: 0, r: 4, period: 5,  high: 2};
    tbl[1] = '{ch: 1, r: 1, period: 2,  high: 1};
    tbl[2] = '{ch: 2, r: 0, period: 1,  high: 0};
    tbl[3] = '{ch: 0, r: 6, period: 7,  high: 3};
    tbl[4] = '{ch: 1, r: 9, period: 10, high: 5};

    rst      = 1'b1;
    div_cfg  = '0;
    cfg_load = '0;
    bypass   = '0;
    ch_en    = '1;
    #3;
    check("reset_outputs", int'({clk_en, clk_div, cfg_pend, lock}), 0);
    tick();
    tick();
    rst = 1'b0;
    lock_seq("boot");

    // Ratio table: load in IDLE, then check first pulse, period and duty.
    foreach (tbl[j]) begin
      load_idle(tbl[j].ch, tbl[j].r);
      check($sformatf("idle_load_no_pend_%0d", j), int'(cfg_pend[tbl[j].ch]), 0);
      wait_en(tbl[j].ch, n, hi);
      check($sformatf("first_pulse_%0d", j), n, tbl[j].period);
      wait_en(tbl[j].ch, n, hi);
      check($sformatf("period_%0d", j), n, tbl[j].period);
      check($sformatf("high_%0d", j), hi, tbl[j].high);
    end

    // Mid-period reload: R=9 -> R=2.
    load_idle(0, 9);
    wait_en(0, n, hi);
    repeat (3) tick();
    set_cfg(0, 2);
    cfg_load[0] = 1'b1;
    tick();
    cfg_load[0] = 1'b0;
    check("pend_set", int'(cfg_pend[0]), 1);
    wait_en(0, n, hi);
    check("old_period_completes", 4 + n, 10);
    check("pend_clear_at_reload", int'(cfg_pend[0]), 0);
    wait_en(0, n, hi);
    check("new_period_3", n, 3);

    // Load coincident with cnt==0 applies immediately.
    tick();
    tick();
    set_cfg(0, 5);
    cfg_load[0] = 1'b1;
    tick();
    cfg_load[0] = 1'b0;
    check("coincident_en", int'(clk_en[0]), 1);
    check("coincident_no_pend", int'(cfg_pend[0]), 0);
    wait_en(0, n, hi);
    check("coincident_period", n, 6);

    // Double load while pending: last one wins.
    tick();
    set_cfg(0, 5);
    cfg_load[0] = 1'b1;
    tick();
    check("double_pend", int'(cfg_pend[0]), 1);
    set_cfg(0, 7);
    tick();
    cfg_load[0] = 1'b0;
    wait_en(0, n, hi);
    check("double_old_completes", 3 + n, 6);
    wait_en(0, n, hi);
    check("double_last_applies", n, 8);

    // Bypass on channel 1 (R=9), then release and CH_EN drop.
    bypass[1] = 1'b1;
    cnt_bad = 0;
    repeat (5) begin
      tick();
      if (!(clk_en[1] == 1'b1 && clk_div[1] == 1'b0)) cnt_bad++;
    end
    check("bypass_const_en", cnt_bad, 0);
    bypass[1] = 1'b0;
    wait_en(1, n, hi);
    check("bypass_release_first_en", n, 10);
    repeat (3) tick();
    check("div_high_mid_period", int'(clk_div[1]), 1);
    ch_en[1] = 1'b0;
    tick();
    check("ch_en_drop_outputs", int'({clk_en[1], clk_div[1]}), 0);
    repeat (3) tick();
    check("ch_en_drop_stays_idle", int'({clk_en[1], clk_div[1]}), 0);

    // Reset mid-run with a pending config on channel 0 (R=7 -> pending 6).
    wait_en(0, n, hi);
    tick();
    set_cfg(0, 6);
    cfg_load[0] = 1'b1;
    tick();
    cfg_load[0] = 1'b0;
    check("pre_reset_pend", int'(cfg_pend[0]), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", int'({clk_en, clk_div, cfg_pend, lock}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lock_seq("rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
